// File: rtl/zf_pam4_demapper_if.sv
// Stream interface of the ZF PAM-4 demapper.
// Carries the equalised vector input handshake and the bit-beat output
// handshake. The demapper uses the slave modport; the upstream ZF stage
// plus the bit sink together form the master side.
interface zf_pam4_demapper_if #(
    parameter int W     = 16,
    parameter int LANES = 8,
    parameter int BPB   = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W*LANES-1:0]   x_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BPB-1:0]       out_bits;
    logic                 out_last;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, out_bits, out_last
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, out_bits, out_last
    );
endinterface

// File: rtl/zf_pam4_demapper.sv
// PAM-4 hard demapper sitting directly behind the ZF detector.
// Each sign-magnitude Q3.12 lane is sliced into two bits (sign bit b1,
// inner/outer bit b0), lanes are packed into one decision word and the
// word is serialised to the sink in BPB-bit beats.
// Optional macro DEMAP_ERASE_CNT_EN adds a saturating count of lanes that
// fell close to a decision boundary (erase_cnt output, MARGIN parameter).
module zf_pam4_demapper #(
    parameter int           W      = 16,
    parameter int           LANES  = 8,
    parameter int           BPB    = 4,
    parameter logic [W-1:0] THR    = 16'h2000
`ifdef DEMAP_ERASE_CNT_EN
    ,
    parameter logic [W-1:0] MARGIN = 16'h0400
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    zf_pam4_demapper_if.slave    bus,
    output logic [15:0]          vec_cnt
`ifdef DEMAP_ERASE_CNT_EN
    ,
    output logic [15:0]          erase_cnt
`endif
);

    localparam int WB = 2 * LANES;
    localparam int NB = WB / BPB;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WB-1:0]   word;
    logic [WB-1:0]   word_nxt;
    logic [WB-1:0]   sliced;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [15:0]     vec_cnt_nxt;
    logic            last_beat;
    logic            capture;
    logic            xfer;

    // Hard PAM-4 decision for one lane: b1 = positive (-0 counts as
    // positive), b0 = inner level (magnitude strictly below THR).
    function automatic logic [1:0] slice_lane(input logic [W-1:0] lane);
        logic [W-1:0] mag;
        mag = {1'b0, lane[W-2:0]};
        slice_lane[1] = ~lane[W-1] | (mag == '0);
        slice_lane[0] = (mag < THR);
    endfunction

    assign bus.out_valid = (state == FULL);
    assign last_beat     = (idx == LAST_IDX);
    assign bus.out_last  = bus.out_valid & last_beat;
    assign bus.out_bits  = word[BPB*idx +: BPB];

    // The ready path looks through the final beat so a new vector can be
    // taken in the same cycle the old one finishes.
    assign bus.in_ready = enable &
                          ((state == EMPTY) | (bus.out_valid & bus.out_ready & bus.out_last));
    assign capture      = bus.in_valid & bus.in_ready;
    assign xfer         = enable & bus.out_valid & bus.out_ready;

    // Slice all lanes of the incoming vector into the candidate word.
    always_comb begin
        sliced = '0;
        for (int k = 0; k < LANES; k++) begin
            sliced[2*k +: 2] = slice_lane(bus.x_in[W*k +: W]);
        end
    end

    // Next-state logic: beat advance first, then a capture overrides it.
    always_comb begin
        state_nxt   = state;
        word_nxt    = word;
        idx_nxt     = idx;
        vec_cnt_nxt = vec_cnt;
        if (xfer) begin
            if (!last_beat) begin
                idx_nxt = idx + 1'b1;
            end else begin
                vec_cnt_nxt = vec_cnt + 16'd1;
                state_nxt   = EMPTY;
            end
        end
        if (capture) begin
            word_nxt  = sliced;
            idx_nxt   = '0;
            state_nxt = FULL;
        end
    end

    // State, word, beat index and vector counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            word    <= '0;
            idx     <= '0;
            vec_cnt <= '0;
        end else begin
            state   <= state_nxt;
            word    <= word_nxt;
            idx     <= idx_nxt;
            vec_cnt <= vec_cnt_nxt;
        end
    end

`ifdef DEMAP_ERASE_CNT_EN
    logic [15:0] erase_add;
    logic [16:0] erase_sum;

    // A lane is unreliable when it sits near zero or near the inner/outer boundary.
    function automatic logic near_boundary(input logic [W-1:0] lane);
        logic [W-1:0] mag;
        logic [W-1:0] dist;
        mag  = {1'b0, lane[W-2:0]};
        dist = (mag >= THR) ? (mag - THR) : (THR - mag);
        near_boundary = (mag < MARGIN) | (dist < MARGIN);
    endfunction

    // Count unreliable lanes in the vector being offered.
    always_comb begin
        erase_add = '0;
        for (int k = 0; k < LANES; k++) begin
            erase_add = erase_add + 16'(near_boundary(bus.x_in[W*k +: W]));
        end
        erase_sum = {1'b0, erase_cnt} + {1'b0, erase_add};
    end

    // Saturating erasure accumulator, updated only on capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erase_cnt <= '0;
        end else if (capture) begin
            erase_cnt <= erase_sum[16] ? 16'hFFFF : erase_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_zf_pam4_demapper.sv
// Self-checking bench for zf_pam4_demapper.
// Expected beats come from a level-based PAM-4 reference model; expected
// vector and erasure counts are tracked by the bench itself.
module tb_zf_pam4_demapper;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] vec_cnt;
`ifdef DEMAP_ERASE_CNT_EN
    logic [15:0] erase_cnt;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_vec = '0;
    int          exp_erase = 0;

    zf_pam4_demapper_if bus ();

    zf_pam4_demapper dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .vec_cnt  (vec_cnt)
`ifdef DEMAP_ERASE_CNT_EN
        ,
        .erase_cnt(erase_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference decision word: classify each lane into a PAM-4 level, then map level to bits.
    function automatic logic [15:0] model_word(input logic [127:0] x);
        logic [15:0] w;
        int          mag;
        int          lvl;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            mag = int'(x[16*k +: 15]);
            lvl = (mag >= 'h2000) ? 3 : 1;
            if (x[16*k+15] && mag != 0) lvl = -lvl;
            case (lvl)
                3:       w[2*k +: 2] = 2'b10;
                1:       w[2*k +: 2] = 2'b11;
                -1:      w[2*k +: 2] = 2'b01;
                default: w[2*k +: 2] = 2'b00;
            endcase
        end
        return w;
    endfunction

    function automatic int model_erase(input logic [127:0] x);
        int mag;
        int d;
        int cnt;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            mag = int'(x[16*k +: 15]);
            d = mag - 'h2000;
            if (d < 0) d = -d;
            if (mag < 'h400 || d < 'h400) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] v;
        logic        s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       v = 16'($urandom);
            1:       v = {s, 15'h2000};
            2:       v = {s, 15'h1FFF};
            3:       v = {s, 15'h0000};
            4:       v = {s, 15'(32'h1C00 + $urandom_range(0, 32'h800))};
            default: v = {s, 15'($urandom_range(0, 32'h800))};
        endcase
        return v;
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] x;
        for (int k = 0; k < 8; k++) x[16*k +: 16] = rand_lane();
        return x;
    endfunction

    function automatic logic ready_of(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector and wait (bounded) until it is taken.
    task automatic capture(input logic [127:0] x, output bit timeout);
        int waited;
        timeout = 0;
        waited = 0;
        bus.x_in = x;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            timeout = 1;
        end else begin
            tick();
            exp_erase = exp_erase + model_erase(x);
            if (exp_erase > 65535) exp_erase = 65535;
        end
        bus.in_valid = 1'b0;
    endtask

    // Capture one vector and drain its beats with the given sink pattern.
    task automatic send_and_collect(input logic [127:0] x, input int mode,
                                    output logic [15:0] beats, output logic [3:0] lasts,
                                    output bit timeout, output bit unstable, output bit bad_ready);
        int          got;
        int          cyc;
        logic [3:0]  held;
        bit          held_v;
        beats = '0;
        lasts = '0;
        unstable = 0;
        bad_ready = 0;
        held = '0;
        held_v = 0;
        bus.out_ready = 1'b0;
        capture(x, timeout);
        if (timeout) return;
        got = 0;
        cyc = 0;
        while (got < NB && cyc < 200) begin
            bus.out_ready = ready_of(mode, cyc);
            #1;
            if (!bus.out_valid) begin
                unstable = 1;
            end else begin
                if (held_v && bus.out_bits !== held) unstable = 1;
                if (bus.in_ready !== (bus.out_ready && got == NB - 1)) bad_ready = 1;
                if (bus.out_ready) begin
                    beats[4*got +: 4] = bus.out_bits;
                    lasts[got] = bus.out_last;
                    got++;
                    held_v = 0;
                end else begin
                    held = bus.out_bits;
                    held_v = 1;
                end
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < NB) timeout = 1;
        else exp_vec = exp_vec + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (bus.out_bits !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_out_bits: got %h want 0", bus.out_bits); end
        n_cmp++; if (vec_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_vec_cnt: got %h want 0", vec_cnt); end
`ifdef DEMAP_ERASE_CNT_EN
        n_cmp++; if (erase_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_erase_cnt: got %h want 0", erase_cnt); end
`endif
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_in_ready_en: got %b want 1", bus.in_ready); end
        enable = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_in_ready_dis: got %b want 0", bus.in_ready); end
        enable = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_mapping();
        logic [127:0] x;
        logic [15:0]  beats;
        logic [3:0]   lasts;
        bit           to, un, br;
        x = {16'h0000, 16'hA000, 16'h2000, 16'h8000, 16'hB000, 16'h9000, 16'h1000, 16'h3000};
        send_and_collect(x, 0, beats, lasts, to, un, br);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL map_timeout: got %b want 0", to); end
        n_cmp++; if (beats !== 16'hCB1E) begin n_fail++; $display("[TB] FAIL map_beats: got %h want cb1e", beats); end
        n_cmp++; if (beats !== model_word(x)) begin n_fail++; $display("[TB] FAIL map_model: got %h want %h", beats, model_word(x)); end
        n_cmp++; if (lasts !== 4'b1000) begin n_fail++; $display("[TB] FAIL map_last: got %b want 1000", lasts); end
        n_cmp++; if (vec_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL map_vec_cnt: got %0d want 1", vec_cnt); end
`ifdef DEMAP_ERASE_CNT_EN
        n_cmp++; if (erase_cnt !== 16'd4) begin n_fail++; $display("[TB] FAIL map_erase_cnt: got %0d want 4", erase_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [127:0] x1, x2;
        logic [31:0]  beats;
        int           nb, ncap;
        bit           gap, cap, last_rdy;
        x1 = rand_vec();
        x2 = rand_vec();
        beats = '0;
        nb = 0;
        ncap = 0;
        gap = 0;
        last_rdy = 0;
        bus.x_in = x1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && nb < 8; c++) begin
            #1;
            cap = bus.in_valid && bus.in_ready;
            if (nb > 0 && !bus.out_valid) gap = 1;
            if (bus.out_valid && bus.out_ready) begin
                beats[4*nb +: 4] = bus.out_bits;
                if (nb == 3) last_rdy = bus.in_ready;
                nb++;
            end
            tick();
            if (cap) begin
                ncap++;
                exp_erase = exp_erase + model_erase(bus.x_in);
                if (exp_erase > 65535) exp_erase = 65535;
                if (ncap == 1) bus.x_in = x2;
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exp_vec = exp_vec + 16'd2;
        n_cmp++; if (nb !== 8) begin n_fail++; $display("[TB] FAIL b2b_beat_count: got %0d want 8", nb); end
        n_cmp++; if (ncap !== 2) begin n_fail++; $display("[TB] FAIL b2b_captures: got %0d want 2", ncap); end
        n_cmp++; if (gap !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_gap: got %b want 0", gap); end
        n_cmp++; if (last_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_last_ready: got %b want 1", last_rdy); end
        n_cmp++; if (beats !== {model_word(x2), model_word(x1)}) begin n_fail++; $display("[TB] FAIL b2b_beats: got %h want %h", beats, {model_word(x2), model_word(x1)}); end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL b2b_vec_cnt: got %0d want %0d", vec_cnt, exp_vec); end
    endtask

    task automatic test_backpressure();
        logic [127:0] x;
        logic [15:0]  beats;
        logic [3:0]   lasts;
        bit           to, un, br;
        x = rand_vec();
        send_and_collect(x, 1, beats, lasts, to, un, br);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_timeout: got %b want 0", to); end
        n_cmp++; if (un !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stable: got unstable=%b want 0", un); end
        n_cmp++; if (br !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got bad=%b want 0", br); end
        n_cmp++; if (beats !== model_word(x)) begin n_fail++; $display("[TB] FAIL bp_beats: got %h want %h", beats, model_word(x)); end
        n_cmp++; if (lasts !== 4'b1000) begin n_fail++; $display("[TB] FAIL bp_last: got %b want 1000", lasts); end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL bp_vec_cnt: got %0d want %0d", vec_cnt, exp_vec); end
    endtask

    task automatic test_enable_stall();
        logic [127:0] x;
        logic [15:0]  w;
        logic [15:0]  beats;
        bit           to, bad_rdy, bad_hold;
        x = rand_vec();
        w = model_word(x);
        beats = '0;
        bad_rdy = 0;
        bad_hold = 0;
        capture(x, to);
        bus.out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            if (bus.out_valid) beats[4*b +: 4] = bus.out_bits;
            tick();
        end
        enable = 1'b0;
        bus.in_valid = 1'b1;
        bus.x_in = ~x;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.in_ready !== 1'b0) bad_rdy = 1;
            if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.out_bits !== w[11:8]) bad_hold = 1;
            tick();
        end
        n_cmp++; if (bad_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready: got bad=%b want 0", bad_rdy); end
        n_cmp++; if (bad_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_hold: got bad=%b want 0", bad_hold); end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL stall_vec_cnt: got %0d want %0d", vec_cnt, exp_vec); end
        enable = 1'b1;
        bus.in_valid = 1'b0;
        for (int b = 2; b < 4; b++) begin
            #1;
            if (bus.out_valid) beats[4*b +: 4] = bus.out_bits;
            tick();
        end
        bus.out_ready = 1'b0;
        exp_vec = exp_vec + 16'd1;
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_timeout: got %b want 0", to); end
        n_cmp++; if (beats !== w) begin n_fail++; $display("[TB] FAIL stall_beats: got %h want %h", beats, w); end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL stall_vec_after: got %0d want %0d", vec_cnt, exp_vec); end
    endtask

    task automatic test_async_reset();
        logic [127:0] x;
        logic [15:0]  beats;
        logic [3:0]   lasts;
        bit           to, un, br;
        x = rand_vec();
        capture(x, to);
        bus.out_ready = 1'b1;
        repeat (2) begin
            #1;
            tick();
        end
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (vec_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL areset_vec_cnt: got %0d want 0", vec_cnt); end
        n_cmp++; if (bus.out_bits !== 4'h0) begin n_fail++; $display("[TB] FAIL areset_out_bits: got %h want 0", bus.out_bits); end
        #2;
        reset = 1'b0;
        exp_vec = '0;
        exp_erase = 0;
        tick();
        x = rand_vec();
        send_and_collect(x, 0, beats, lasts, to, un, br);
        n_cmp++; if (beats !== model_word(x)) begin n_fail++; $display("[TB] FAIL areset_restart_beats: got %h want %h", beats, model_word(x)); end
        n_cmp++; if (vec_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL areset_restart_cnt: got %0d want 1", vec_cnt); end
`ifdef DEMAP_ERASE_CNT_EN
        n_cmp++; if (erase_cnt !== 16'(exp_erase)) begin n_fail++; $display("[TB] FAIL areset_erase_cnt: got %0d want %0d", erase_cnt, exp_erase); end
`endif
    endtask

    task automatic test_boundary();
        logic [127:0] x;
        logic [15:0]  beats;
        logic [3:0]   lasts;
        bit           to, un, br;
        x = {8{16'h1FFF}};
        send_and_collect(x, 0, beats, lasts, to, un, br);
        n_cmp++; if (beats !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL boundary_beats: got %h want ffff", beats); end
        x = {8{16'h2000}};
        send_and_collect(x, 0, beats, lasts, to, un, br);
        n_cmp++; if (beats !== 16'hAAAA) begin n_fail++; $display("[TB] FAIL boundary_thr_beats: got %h want aaaa", beats); end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL boundary_vec_cnt: got %0d want %0d", vec_cnt, exp_vec); end
    endtask

    task automatic test_random();
        logic [127:0] x;
        logic [15:0]  beats;
        logic [3:0]   lasts;
        bit           to, un, br;
        for (int n = 0; n < 24; n++) begin
            x = rand_vec();
            send_and_collect(x, 2, beats, lasts, to, un, br);
            n_cmp++; if (to || un || br) begin n_fail++; $display("[TB] FAIL rand_handshake[%0d]: got to=%b un=%b br=%b want 0", n, to, un, br); end
            n_cmp++; if (beats !== model_word(x)) begin n_fail++; $display("[TB] FAIL rand_beats[%0d]: got %h want %h", n, beats, model_word(x)); end
            n_cmp++; if (lasts !== 4'b1000) begin n_fail++; $display("[TB] FAIL rand_last[%0d]: got %b want 1000", n, lasts); end
        end
        n_cmp++; if (vec_cnt !== exp_vec) begin n_fail++; $display("[TB] FAIL rand_vec_cnt: got %0d want %0d", vec_cnt, exp_vec); end
`ifdef DEMAP_ERASE_CNT_EN
        n_cmp++; if (erase_cnt !== 16'(exp_erase)) begin n_fail++; $display("[TB] FAIL rand_erase_cnt: got %0d want %0d", erase_cnt, exp_erase); end
`endif
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_back_to_back();
        test_backpressure();
        test_enable_stall();
        test_boundary();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/zf_pam4_demapper.md
Name: zf_pam4_demapper

Overview:
- Stage directly downstream of the ZF detector.
- Accepts the 128-bit equalised estimate X: 8 lanes of 16-bit sign-magnitude Q3.12.
- Each lane is hard-sliced as PAM-4, giving 2 bits per lane; a lane pair (re, im) forms one 16-QAM symbol.
- The resulting 16-bit decision word is serialised to the bit sink in BPB-bit beats over a valid/ready handshake.
- Connections to the ZF block: its ready_out drives in_valid; in_ready drives its accept_in.

Parameters:
- W, 16, lane width; sign at bit W-1, magnitude in [W-2:0], Q3.12.
- LANES, 8, lanes per input vector; x_in width = W*LANES.
- BPB, 4, bits per output beat; must divide 2*LANES; beats per vector NB = 2*LANES/BPB.
- THR, 16'h2000, inner/outer decision boundary, value 2.0 in Q3.12.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global stall; when low, no capture, no beat advance, all state held.
- in_valid  in  1  X vector available.
- in_ready  out  1  block can take a vector this cycle.
- x_in  in  W*LANES  lane k occupies [W*k+W-1 : W*k].
- out_valid  out  1  out_bits holds a valid beat.
- out_ready  in  1  sink accepts the beat.
- out_bits  out  BPB  current beat.
- out_last  out  1  high on beat NB-1 of a vector.
- vec_cnt  out  16  vectors fully emitted; wraps at 65535 -> 0.

Behaviour:
- Reset (async, active-high) values:
  - out_valid=0, out_last=0, out_bits=0, vec_cnt=0.
  - Internal word=0, beat index=0, state=EMPTY.
  - in_ready evaluates to enable while in reset-released EMPTY state.
- Slicing, per lane, combinational at capture:
  - b1 = 1 if positive, where magnitude==0 counts as positive regardless of sign bit (-0 -> positive).
  - b0 = 1 if magnitude < THR; magnitude == THR slices outer (b0=0).
  - Resulting mapping: +3->10, +1->11, -1->01, -3->00.
  - Lane k's b1 goes to word[2k+1] and b0 to word[2k].
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; out_bits = word[BPB*idx+BPB-1 : BPB*idx]; out_last = (idx==NB-1).
- Capture:
  - Occurs on a clock edge with enable & in_valid & in_ready.
  - Registers the sliced word, sets idx=0, enters FULL.
  - Latency: out_valid rises the cycle after capture.
- Beat transfer:
  - Occurs on a clock edge with enable & out_valid & out_ready.
  - If idx < NB-1: idx increments.
  - If idx == NB-1: vec_cnt increments; the state goes to EMPTY unless a capture happens in the same cycle.
- in_ready = enable & (state==EMPTY | (out_valid & out_ready & out_last)).
  - Combinational path from out_ready; allows back-to-back vectors with no bubble.
  - Simultaneous last-beat transfer and capture: the new word loads, idx=0, state stays FULL.
- Sink backpressure: out_ready low holds out_bits and out_last stable; no beat is lost or repeated.
- enable low: state, idx and the word are frozen. out_valid stays at its current value, but no transfer counts.
- Reset asserted mid-vector: the partial vector is discarded, all state goes to reset values, vec_cnt clears.

Optional Feature:
- Macro: DEMAP_ERASE_CNT_EN.
- When defined:
  - Adds parameter MARGIN (default 16'h0400, 0.25) and output port erase_cnt [15:0], reset 0.
  - At each capture, add to erase_cnt the number of lanes whose magnitude < MARGIN, or whose |magnitude - THR| < MARGIN.
  - erase_cnt saturates at 16'hFFFF.
- When undefined: no port, no logic; all other behaviour identical.

Test Plan:
- Mapping vector:
  - Stimulus: lanes 0..7 = 3000,1000,9000,B000,8000,2000,A000,0000 (hex), out_ready=1.
  - Response: beats E,1,B,C; out_last on beat 3 only; vec_cnt=1.
  - With DEMAP_ERASE_CNT_EN: erase_cnt=4 (lanes 4, 5, 6, 7).
- Back-to-back:
  - Stimulus: two vectors offered continuously with in_valid=1, out_ready=1.
  - Response: 8 consecutive out_valid beats with no gap; in_ready=1 in the last-beat cycle; vec_cnt=2.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... during a vector.
  - Response: out_bits is stable while out_ready=0; exactly 4 beats emitted in order; in_ready=0 until the last beat is accepted.
- enable stall:
  - Stimulus: drop enable for 5 cycles mid-vector (at idx=2), with in_valid=1.
  - Response: idx holds at 2; in_ready=0; no capture; resuming gives beats 2,3.
- Async reset:
  - Stimulus: assert reset between clock edges after beat 1.
  - Response: out_valid=0 and vec_cnt=0 immediately; after release, a new vector emits from beat 0.
- Boundary lanes:
  - Stimulus: all lanes = 1FFF (just below THR).
  - Response: word FFFF, beats F,F,F,F.
